// File: rtl/ct_clk_lpmd_pkg.sv
// Shared clock-control definitions: low-power sequencer state encodings and
// default delay settings.
package ct_clk_lpmd_pkg;

   typedef enum logic [1:0] {
      LPMD_RUN   = 2'b00,
      LPMD_DRAIN = 2'b01,
      LPMD_GATED = 2'b10,
      LPMD_WAKE  = 2'b11
   } lpmd_state_e;

   localparam int LPMD_IDLE_DLY = 4;
   localparam int LPMD_WAKE_DLY = 2;
   localparam int LPMD_CNT_W    = 4;

endpackage

// File: rtl/ct_clk_lpmd_ctrl.sv
// Low-power-mode sequencer for the global core clock gate: drains the core on
// a WFI request, gates the clock, and reopens it on a wakeup event.
module ct_clk_lpmd_ctrl
   import ct_clk_lpmd_pkg::*;
#(
   parameter int IDLE_DLY = LPMD_IDLE_DLY,
   parameter int WAKE_DLY = LPMD_WAKE_DLY,
   parameter int CNT_W    = LPMD_CNT_W
) (
   input  logic       forever_coreclk,
   input  logic       cpurst_b,
   input  logic       cp0_clk_lpmd_req,
   input  logic       rtu_clk_pipe_empty,
   input  logic       biu_clk_bus_idle,
   input  logic       biu_xx_int_wakeup,
   input  logic       biu_xx_dbg_wakeup,
   input  logic       biu_xx_snoop_vld,
   input  logic       had_xx_clk_en,
   input  logic       cp0_xx_core_icg_en,
   output logic       core_clk_en,
   output logic       clk_cp0_lpmd_ack,
   output logic       clk_cp0_wakeup_done,
   output logic [1:0] clk_xx_lpmd_state
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_DLY - 1);
   localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_DLY - 1);

   lpmd_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             wake_evt, qual, force_on;

   assign wake_evt = biu_xx_int_wakeup | biu_xx_dbg_wakeup;
   assign qual     = cp0_clk_lpmd_req & rtu_clk_pipe_empty & biu_clk_bus_idle & ~had_xx_clk_en;
   assign force_on = biu_xx_snoop_vld | had_xx_clk_en | cp0_xx_core_icg_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      // Terminal values fire before saturation, so the hold is only a guard.
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         LPMD_RUN: begin
            if (cp0_clk_lpmd_req && !wake_evt) begin
               state_d = LPMD_DRAIN;
               cnt_d   = '0;
            end
         end
         LPMD_DRAIN: begin
            if (wake_evt || !cp0_clk_lpmd_req) begin
               state_d = LPMD_RUN;
               cnt_d   = '0;
            end else if (!qual) begin
               cnt_d = '0;
            end else if (cnt_q == IDLE_TERM) begin
               state_d = LPMD_GATED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         LPMD_GATED: begin
            if (wake_evt) begin
               state_d = LPMD_WAKE;
               cnt_d   = '0;
            end
         end
         LPMD_WAKE: begin
            if (cnt_q == WAKE_TERM) begin
               state_d = LPMD_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = LPMD_RUN;
            cnt_d   = '0;
         end
      endcase
      ack_d  = (state_q == LPMD_DRAIN) && (state_d == LPMD_GATED);
      done_d = (state_q == LPMD_WAKE)  && (state_d == LPMD_RUN);
   end

   always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= LPMD_RUN;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   // Only GATED closes the gate; reset forces RUN, so the enable returns asynchronously.
   assign core_clk_en         = (state_q == LPMD_GATED) ? force_on : 1'b1;
   assign clk_cp0_lpmd_ack    = ack_q;
   assign clk_cp0_wakeup_done = done_q;
   assign clk_xx_lpmd_state   = state_q;

endmodule
